ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the single-port program/data RAM between the CPU instruction-fetch and load/store
//  ports. Sits between core and ram inside top. Serialises one access at a time through a
//  fixed issue/wait/respond sequence, with round-robin arbitration and req/ack handshakes.
//  Reads back 32-bit words; flags out-of-range addresses without touching the RAM.
// PARAMETERS
//  ADDR_WIDTH   16    word-address width on all ports
//  DATA_WIDTH   32    data width; byte enables are DATA_WIDTH/8 wide
//  MEM_WORDS    4096  implemented RAM words; addr >= MEM_WORDS is out of range
//  RAM_LATENCY  1     cycles from ram_en sample edge to valid ram_rdata (>=1)
// PORTS
//  clk        in   1            system clock
//  reset      in   1            asynchronous, active-high reset
//  i_req      in   1            fetch request; held with i_addr until i_ack
//  i_addr     in   ADDR_WIDTH   fetch word address
//  i_ack      out  1            one-cycle pulse: i_rdata/i_err valid
//  i_rdata    out  DATA_WIDTH   fetched word
//  i_err      out  1            fetch address out of range (valid with i_ack)
//  d_req      in   1            load/store request; held with d_* until d_ack
//  d_we       in   1            1 = store, 0 = load
//  d_be       in   DATA_WIDTH/8 store byte enables
//  d_addr     in   ADDR_WIDTH   data word address
//  d_wdata    in   DATA_WIDTH   store data
//  d_ack      out  1            one-cycle pulse: access complete, d_rdata/d_err valid
//  d_rdata    out  DATA_WIDTH   load data (0 for stores)
//  d_err      out  1            data address out of range (valid with d_ack)
//  ram_en     out  1            RAM access strobe, exactly one cycle per access
//  ram_we     out  1            RAM write enable (qualified by ram_en)
//  ram_be     out  DATA_WIDTH/8 RAM byte enables (0 on reads)
//  ram_addr   out  ADDR_WIDTH   RAM word address
//  ram_wdata  out  DATA_WIDTH   RAM write data
//  ram_rdata  in   DATA_WIDTH   RAM read data, valid RAM_LATENCY cycles after ram_en edge
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, last_grant = D (first tie goes to I). Asserting reset
//    mid-access aborts it: no ack, no further RAM cycle; requester must re-issue.
//  - FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. All outputs registered.
//    IDLE: if any req, pick winner, latch its addr/we/be/wdata and grant -> ISSUE.
//    ISSUE (1 cycle): ram_en=1 with latched fields (ram_en=0, no RAM cycle, if out of range).
//    WAIT (RAM_LATENCY cycles, down-counter): at last cycle capture ram_rdata (or 0 on
//      store/out-of-range) into winner's rdata, set err -> RESP.
//    RESP (1 cycle): winner's ack=1; req inputs ignored this cycle -> IDLE.
//  - Latency: req first seen high in cycle N -> ack in cycle N+2+RAM_LATENCY. Same for
//    loads, stores and out-of-range. Max throughput one access per 3+RAM_LATENCY cycles.
//  - Arbitration: lone requester always wins. Both requesting in IDLE: grant the port not
//    granted last; last_grant updated on every grant. Guarantees no starvation.
//  - Address stable rule: inputs sampled only in IDLE; changes after grant are ignored.
//  - req dropped before ack (protocol violation): access still completes, ack still pulses.
//  - i port never writes: ram_we=0, ram_be=0 for I grants. d_be ignored on loads.
//  - rdata/err hold their value between acks; non-granted port's ack stays 0.
//  - Range check: err = (addr >= MEM_WORDS), computed at ADDR_WIDTH+1 bits, no wrap.
// STRUCTURE
//  - Package ktc32_mem_pkg: grant_e {GRANT_I, GRANT_D}, arb_state_e {IDLE, ISSUE, WAIT,
//    RESP}, DATA_WIDTH/BE_WIDTH localparams shared with ram and core.
//  - Sub-module rr_arbiter2: combinational 2-way round-robin picker (req_i, req_d,
//    last_grant -> grant); FSM, latch registers and latency counter stay in this module.
// TESTING
//  1 Reset: reset=1 async mid-cycle -> all outputs 0 immediately; after release, no ram_en
//    while both req low.
//  2 Lone fetch: RAM preloaded mem[0x10]=0xDEADBEEF, i_req addr 0x10 in cycle N -> ram_en
//    one cycle at N+1, i_ack in N+3 with i_rdata=0xDEADBEEF, i_err=0, d_ack=0.
//  3 Store then load: d_we=1 be=4'b0011 addr 0x20 wdata 0x12345678 over 0xAAAAAAAA -> d_ack,
//    d_rdata=0; then load 0x20 -> d_rdata=0xAAAA5678.
//  4 Contention: i_req and d_req held high for 4 accesses from reset -> grant order I,D,I,D;
//    ram_addr alternates; each ack exactly once per access.
//  5 Out of range: d_req load addr 0x1000 (MEM_WORDS=4096) -> no ram_en, d_ack at N+3 with
//    d_err=1, d_rdata=0; next in-range access has err=0.
//  6 Reset mid-access: reset pulsed during WAIT -> no ack follows; re-issued request
//    completes normally with correct data; RAM_LATENCY=3 run gives ack at N+5.

Source files
------------

// File: rtl/ktc32_mem_pkg.sv
// Shared memory-subsystem types and widths for the ktc32 core, RAM and port arbiter.
package ktc32_mem_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/ram_port_arbiter_rr_arbiter2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port not granted last.
module rr_arbiter2
    import ktc32_mem_pkg::*;
(
    input  logic   req_i_i,
    input  logic   req_d_i,
    input  grant_e last_grant_i,
    output grant_e grant_o
);

    always_comb begin
        grant_o = GRANT_I;
        if (req_i_i && req_d_i) begin
            grant_o = (last_grant_i == GRANT_D) ? GRANT_I : GRANT_D;
        end else if (req_d_i) begin
            grant_o = GRANT_D;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Serialises instruction-fetch and load/store accesses onto the single-port RAM through a
// fixed IDLE -> ISSUE -> WAIT -> RESP sequence with registered outputs.
module ram_port_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = ktc32_mem_pkg::DATA_WIDTH,
    parameter int unsigned MEM_WORDS   = 4096,
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_req,
    input  logic [ADDR_WIDTH-1:0]     i_addr,
    output logic                      i_ack,
    output logic [DATA_WIDTH-1:0]     i_rdata,
    output logic                      i_err,
    input  logic                      d_req,
    input  logic                      d_we,
    input  logic [DATA_WIDTH/8-1:0]   d_be,
    input  logic [ADDR_WIDTH-1:0]     d_addr,
    input  logic [DATA_WIDTH-1:0]     d_wdata,
    output logic                      d_ack,
    output logic [DATA_WIDTH-1:0]     d_rdata,
    output logic                      d_err,
    output logic                      ram_en,
    output logic                      ram_we,
    output logic [DATA_WIDTH/8-1:0]   ram_be,
    output logic [ADDR_WIDTH-1:0]     ram_addr,
    output logic [DATA_WIDTH-1:0]     ram_wdata,
    input  logic [DATA_WIDTH-1:0]     ram_rdata
);

    import ktc32_mem_pkg::*;

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned CNT_W = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_WORDS);

    arb_state_e             state_q;
    grant_e                 last_grant_q;
    grant_e                 grant_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   store_q;
    logic                   oor_q;

    logic                   ram_en_q;
    logic                   ram_we_q;
    logic [BE_W-1:0]        ram_be_q;
    logic [ADDR_WIDTH-1:0]  ram_addr_q;
    logic [DATA_WIDTH-1:0]  ram_wdata_q;
    logic                   i_ack_q;
    logic [DATA_WIDTH-1:0]  i_rdata_q;
    logic                   i_err_q;
    logic                   d_ack_q;
    logic [DATA_WIDTH-1:0]  d_rdata_q;
    logic                   d_err_q;

    grant_e                 pick_d;
    logic [ADDR_WIDTH-1:0]  addr_d;
    logic                   store_d;
    logic                   oor_d;
    logic [DATA_WIDTH-1:0]  resp_data_d;

    rr_arbiter2 u_rr (
        .req_i_i      (i_req),
        .req_d_i      (d_req),
        .last_grant_i (last_grant_q),
        .grant_o      (pick_d)
    );

    // Range check is one bit wider than the address so MEM_WORDS == 2**ADDR_WIDTH cannot wrap.
    assign addr_d      = (pick_d == GRANT_D) ? d_addr : i_addr;
    assign store_d     = (pick_d == GRANT_D) && d_we;
    assign oor_d       = ({1'b0, addr_d} >= MEM_LIMIT);
    assign resp_data_d = (store_q || oor_q) ? '0 : ram_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_D;
            grant_q      <= GRANT_I;
            cnt_q        <= '0;
            store_q      <= 1'b0;
            oor_q        <= 1'b0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_be_q     <= '0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            i_ack_q      <= 1'b0;
            i_rdata_q    <= '0;
            i_err_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            d_rdata_q    <= '0;
            d_err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req || d_req) begin
                        grant_q      <= pick_d;
                        last_grant_q <= pick_d;
                        store_q      <= store_d;
                        oor_q        <= oor_d;
                        ram_en_q     <= !oor_d;
                        ram_we_q     <= store_d && !oor_d;
                        ram_be_q     <= (store_d && !oor_d) ? d_be : '0;
                        ram_addr_q   <= addr_d;
                        ram_wdata_q  <= store_d ? d_wdata : '0;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    ram_en_q <= 1'b0;
                    ram_we_q <= 1'b0;
                    ram_be_q <= '0;
                    cnt_q    <= CNT_W'(RAM_LATENCY - 1);
                    state_q  <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        if (grant_q == GRANT_I) begin
                            i_rdata_q <= resp_data_d;
                            i_err_q   <= oor_q;
                            i_ack_q   <= 1'b1;
                        end else begin
                            d_rdata_q <= resp_data_d;
                            d_err_q   <= oor_q;
                            d_ack_q   <= 1'b1;
                        end
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    i_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_be    = ram_be_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign i_ack     = i_ack_q;
    assign i_rdata   = i_rdata_q;
    assign i_err     = i_err_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: one instance at RAM_LATENCY=1, one at RAM_LATENCY=3,
// each backed by a small behavioural RAM.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic        i_req, d_req, d_we;
    logic [15:0] i_addr, d_addr;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic        i_ack, i_err, d_ack, d_err;
    logic [31:0] i_rdata, d_rdata;
    logic        ram_en, ram_we;
    logic [3:0]  ram_be;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    logic        i3_req, d3_req, d3_we;
    logic [15:0] i3_addr, d3_addr;
    logic [3:0]  d3_be;
    logic [31:0] d3_wdata;
    logic        i3_ack, i3_err, d3_ack, d3_err;
    logic [31:0] i3_rdata, d3_rdata;
    logic        ram3_en, ram3_we;
    logic [3:0]  ram3_be;
    logic [15:0] ram3_addr;
    logic [31:0] ram3_wdata, ram3_rdata;

    logic        pl_en;
    logic [11:0] pl_addr;
    logic [31:0] pl_data;

    logic [31:0] mem1 [0:4095];
    logic [31:0] mem3 [0:4095];
    logic [31:0] p3_0, p3_1;

    int vec_cnt    = 0;
    int miscmp_cnt = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_WORDS(4096), .RAM_LATENCY(1)
    ) dut1 (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    ram_port_arbiter #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_WORDS(4096), .RAM_LATENCY(3)
    ) dut3 (
        .clk(clk), .reset(reset),
        .i_req(i3_req), .i_addr(i3_addr), .i_ack(i3_ack), .i_rdata(i3_rdata), .i_err(i3_err),
        .d_req(d3_req), .d_we(d3_we), .d_be(d3_be), .d_addr(d3_addr), .d_wdata(d3_wdata),
        .d_ack(d3_ack), .d_rdata(d3_rdata), .d_err(d3_err),
        .ram_en(ram3_en), .ram_we(ram3_we), .ram_be(ram3_be), .ram_addr(ram3_addr),
        .ram_wdata(ram3_wdata), .ram_rdata(ram3_rdata)
    );

    // Read data outside its valid window is a marker value so latency slips show up.
    always @(posedge clk) begin
        if (pl_en) begin
            mem1[pl_addr] <= pl_data;
            mem3[pl_addr] <= pl_data;
        end
        ram_rdata <= ram_en ? mem1[ram_addr[11:0]] : 32'hBAD0_BAD0;
        if (ram_en && ram_we)
            for (int b = 0; b < 4; b++)
                if (ram_be[b]) mem1[ram_addr[11:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
        p3_0       <= ram3_en ? mem3[ram3_addr[11:0]] : 32'hBAD0_BAD0;
        p3_1       <= p3_0;
        ram3_rdata <= p3_1;
        if (ram3_en && ram3_we)
            for (int b = 0; b < 4; b++)
                if (ram3_be[b]) mem3[ram3_addr[11:0]][8*b +: 8] <= ram3_wdata[8*b +: 8];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en   = 1'b0;
    endtask

    // Issues one access on dut1 from an IDLE cycle, returns in the IDLE cycle after the ack.
    task automatic access(input string pfx, input bit is_d, input bit we, input logic [3:0] be,
                          input logic [15:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int en_cnt, output logic en_we, output logic [3:0] en_be,
                          output logic [15:0] en_addr);
        bit done;
        done = 1'b0; lat = 0; en_cnt = 0; rdata = '0; err = 1'b0;
        en_we = 1'b0; en_be = '0; en_addr = '0;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        for (int k = 1; k <= 12 && !done; k++) begin
            tick();
            if (ram_en) begin
                en_cnt++; en_we = ram_we; en_be = ram_be; en_addr = ram_addr;
            end
            if (k == 1) begin
                i_addr = 16'h0FFE; d_addr = 16'h0FFE; d_wdata = 32'h5555_5555;
            end
            if (is_d ? d_ack : i_ack) begin
                done  = 1'b1;
                lat   = k;
                rdata = is_d ? d_rdata : i_rdata;
                err   = is_d ? d_err : i_err;
                check({pfx, "_other_ack"}, is_d ? i_ack : d_ack, 0);
                i_req = 1'b0; d_req = 1'b0;
            end
        end
        if (!done) begin
            check({pfx, "_ack_timeout"}, 0, 1);
            i_req = 1'b0; d_req = 1'b0;
        end
        tick();
        check({pfx, "_ack_pulse"}, {i_ack, d_ack}, 0);
        check({pfx, "_hold"}, is_d ? {d_rdata, 31'd0, d_err} : {i_rdata, 31'd0, i_err},
              {rdata, 31'd0, err});
    endtask

    logic [31:0] rd;
    logic        er, ewe;
    logic [3:0]  ebe;
    logic [15:0] ead;
    int          lat, enc;

    initial begin
        reset = 1'b1;
        i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_be = '0; d_wdata = '0;
        i3_req = 0; d3_req = 0; d3_we = 0; i3_addr = '0; d3_addr = '0; d3_be = '0; d3_wdata = '0;
        pl_en = 0; pl_addr = '0; pl_data = '0;

        preload(12'h010, 32'hDEAD_BEEF);
        preload(12'h020, 32'hAAAA_AAAA);
        preload(12'h030, 32'h0000_3030);
        preload(12'h040, 32'h0000_4040);
        preload(12'hFFF, 32'hCAFE_F00D);
        check("rst_data", {i_rdata, d_rdata}, 0);
        check("rst_ctl", {i_ack, i_err, d_ack, d_err, ram_en, ram_we, ram_be, ram_addr}, 0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("idle_no_en", {ram_en, i_ack, d_ack}, 0);
        end

        access("fetch", 0, 0, 4'h0, 16'h0010, 32'h0, rd, er, lat, enc, ewe, ebe, ead);
        check("fetch_rdata", rd, 32'hDEAD_BEEF);
        check("fetch_err", er, 0);
        check("fetch_lat", lat, 3);
        check("fetch_en_cnt", enc, 1);
        check("fetch_ram", {ewe, ebe, ead}, {1'b0, 4'h0, 16'h0010});

        access("store", 1, 1, 4'b0011, 16'h0020, 32'h1234_5678, rd, er, lat, enc, ewe, ebe, ead);
        check("store_rdata", rd, 0);
        check("store_err", er, 0);
        check("store_lat", lat, 3);
        check("store_ram", {ewe, ebe, ead, 32'(enc)}, {1'b1, 4'b0011, 16'h0020, 32'd1});

        #3 reset = 1'b1;
        #1;
        check("async_rst_data", {i_rdata, d_rdata}, 0);
        check("async_rst_ctl", {i_ack, i_err, d_ack, d_err, ram_en, ram_we, ram_be, ram_addr}, 0);
        check("async_rst_wdata", ram_wdata, 0);
        tick();
        #2 reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_rst_no_en", ram_en, 0);
        end

        access("load", 1, 0, 4'hF, 16'h0020, 32'hFFFF_FFFF, rd, er, lat, enc, ewe, ebe, ead);
        check("load_rdata", rd, 32'hAAAA_5678);
        check("load_lat", lat, 3);
        check("load_ram", {ewe, ebe, ead, 32'(enc)}, {1'b0, 4'h0, 16'h0020, 32'd1});

        access("oor_d", 1, 0, 4'h0, 16'h1000, 32'h0, rd, er, lat, enc, ewe, ebe, ead);
        check("oor_d_err", er, 1);
        check("oor_d_rdata", rd, 0);
        check("oor_d_lat", lat, 3);
        check("oor_d_en_cnt", enc, 0);
        access("edge_d", 1, 0, 4'h0, 16'h0FFF, 32'h0, rd, er, lat, enc, ewe, ebe, ead);
        check("edge_d_err", er, 0);
        check("edge_d_rdata", rd, 32'hCAFE_F00D);
        access("oor_i", 0, 0, 4'h0, 16'hFFFF, 32'h0, rd, er, lat, enc, ewe, ebe, ead);
        check("oor_i_err", er, 1);
        check("oor_i_rdata", rd, 0);
        check("oor_i_en_cnt", enc, 0);

        #2 reset = 1'b1;
        #2 reset = 1'b0;
        i_req = 1'b1; i_addr = 16'h0030;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 16'h0040;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("cont_en", ram_en, (k == 1 || k == 5 || k == 9 || k == 13));
            if (ram_en) check("cont_addr", ram_addr, (k == 5 || k == 13) ? 16'h0040 : 16'h0030);
            check("cont_iack", i_ack, (k == 3 || k == 11));
            check("cont_dack", d_ack, (k == 7 || k == 15));
            if (i_ack) check("cont_irdata", i_rdata, 32'h0000_3030);
            if (d_ack) check("cont_drdata", d_rdata, 32'h0000_4040);
            if (k == 15) begin
                i_req = 1'b0; d_req = 1'b0;
            end
        end
        tick();
        check("cont_idle", ram_en, 0);

        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
        tick();
        check("abort_issue_en", ram_en, 1);
        tick();
        #2 reset = 1'b1; d_req = 1'b0;
        #2 reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("abort_no_ack", {i_ack, d_ack, ram_en}, 0);
        end
        check("abort_rdata", d_rdata, 0);
        access("reissue", 1, 0, 4'h0, 16'h0020, 32'h0, rd, er, lat, enc, ewe, ebe, ead);
        check("reissue_rdata", rd, 32'hAAAA_5678);
        check("reissue_lat", lat, 3);

        i3_req = 1'b1; i3_addr = 16'h0010;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("l3_en", ram3_en, (k == 1));
            if (k == 1) check("l3_ram", {ram3_we, ram3_be, ram3_addr, ram3_wdata},
                              {1'b0, 4'h0, 16'h0010, 32'h0});
            check("l3_iack", i3_ack, (k == 5));
            check("l3_dack", d3_ack, 0);
            if (k == 5) begin
                check("l3_rdata", {i3_rdata, 31'd0, i3_err}, {32'hDEAD_BEEF, 32'd0});
                i3_req = 1'b0;
            end
        end
        check("l3_d_idle", {d3_rdata, 31'd0, d3_err}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
